rs_ctrl: RTL
============

RS_CTRL -- requirements
Module: rs_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, symbol width in bits.
REQ-002 SHALL have parameter NPAR, default 16, encoder parity symbols (2T, T=8).
REQ-003 SHALL have parameter K_MAX, default 239, largest legal data symbols per block.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cfg_k  in  8  data symbols per block (shortened K); sampled at block start.
REQ-008 cfg_t  in  4  kept parity pairs (punctured T); sampled at block start.
REQ-009 cfg_err  out  1  one-cycle pulse: illegal cfg_k rejected.
REQ-010 in_data / in_valid / in_ready  in / in / out  W / 1 / 1  input symbol stream, valid/ready handshake.
REQ-011 out_data / out_valid / out_ready / out_last  out / out / in / out  W / 1 / 1 / 1  coded symbol stream; out_last marks final symbol of block.
REQ-012 enc_clr / enc_en / enc_sel / enc_din  out / out / out / out  1 / 1 / 1 / W  encoder control: clear parity register; advance one symbol; 0=feed data, 1=shift parity; data symbol.
REQ-013 enc_dout  in  W  encoder top parity register (next parity symbol), valid combinationally.

Function
REQ-014 SHALL implement states IDLE, DATA, PARITY.
REQ-015 IDLE: when in_valid and cfg legal, SHALL latch cfg_k, min(cfg_t,8), pulse enc_clr one cycle, go to DATA; in_ready SHALL be 0 in IDLE.
REQ-016 cfg_k==0 or cfg_k>K_MAX SHALL pulse cfg_err, stay IDLE, consume nothing.
REQ-017 DATA: in_ready = !out_valid || out_ready; on acceptance SHALL load out_data<=in_data, out_valid<=1, drive enc_en=1, enc_sel=0, enc_din=in_data same cycle.
REQ-018 Data latency input acceptance to out_valid SHALL be exactly 1 cycle; full throughput (1 symbol/cycle) when out_ready held high.
REQ-019 After cfg_k-th accepted symbol SHALL go to PARITY, or IDLE with out_last on that symbol if latched t==0.
REQ-020 PARITY: when !out_valid || out_ready SHALL load out_data<=enc_dout, enc_en=1, enc_sel=1; exactly 2*t parity symbols emitted, remaining NPAR-2*t discarded (never shifted).
REQ-021 out_last SHALL accompany last emitted symbol of block; then IDLE.
REQ-022 out_valid SHALL hold with out_data stable until out_ready; enc_en SHALL never assert while output register stalled.
REQ-023 Back-to-back blocks: at most one IDLE bubble cycle between out_last acceptance slot and next block's first acceptance.
REQ-024 cfg_* changes mid-block SHALL have no effect until next IDLE sampling.
REQ-025 Symbol counter SHALL be 8 bits, count to latched k then 2*t, never wrap.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE, counters 0, out_valid=0, out_last=0, out_data=0, in_ready=0, cfg_err=0, enc_clr=enc_en=enc_sel=0, enc_din=0.
REQ-027 Reset mid-block SHALL abandon block; first block after release SHALL start with enc_clr.

Configuration
REQ-028 Macro RS_CTRL_BYPASS_EN defined: SHALL add input cfg_bypass (1 bit, sampled at block start); when 1, block emits cfg_k data symbols only, out_last on last, enc_en never asserted.
REQ-029 Macro undefined: no cfg_bypass port; encoding always on.

Structure
REQ-030 Shared package rs_pkg SHALL hold W, NPAR, K_MAX, T_MAX=8 and state encoding.
REQ-031 Sub-module rs_ctrl_oreg SHALL implement output register and stall logic; encoder lives outside rs_ctrl.

Verification
REQ-032 cfg_k=36, cfg_t=2, out_ready=1 -> 40 outputs, 36 equal inputs, 4 equal enc_dout samples, out_last on 40th, enc_en asserted 40 cycles.
REQ-033 cfg_k=36, cfg_t=2, out_ready toggling 1/0 -> same 40 symbols in order, no enc_en while stalled, data stable during stalls.
REQ-034 cfg_k=10, cfg_t=0 -> 10 outputs, out_last on 10th, no enc_sel=1 cycles.
REQ-035 cfg_k=0 then cfg_k=240 -> two cfg_err pulses, in_ready stays 0, no outputs.
REQ-036 reset_n low after 5 data symbols of cfg_k=36 -> all outputs 0 immediately; next block begins with enc_clr pulse.
REQ-037 RS_CTRL_BYPASS_EN, cfg_bypass=1, cfg_k=20 -> 20 outputs, out_last on 20th, enc_en never 1.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the Reed-Solomon encoder controller: default
// geometry of the RS(255,239) code and the controller state encoding.
package rs_pkg;

  localparam int W     = 8;    // symbol width in bits
  localparam int NPAR  = 16;   // parity symbols produced by the encoder (2T)
  localparam int K_MAX = 239;  // largest legal data symbols per block
  localparam int T_MAX = 8;    // largest number of kept parity pairs

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/rs_ctrl_oreg.sv
// Output register of the coded symbol stream: holds a symbol until the
// consumer takes it and tells the controller when a new one may be loaded.
module rs_ctrl_oreg #(
  parameter int W = rs_pkg::W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         out_ready_i,
  output logic         can_load_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o
);

  logic         valid_q;
  logic         last_q;
  logic [W-1:0] data_q;

  // A slot is free when empty or when the held symbol leaves this cycle.
  assign can_load_o = !valid_q || out_ready_i;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (load_i && can_load_o) begin
      valid_q <= 1'b1;
      last_q  <= last_i;
      data_q  <= data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/rs_ctrl.sv
// Reed-Solomon encoder controller: streams shortened data blocks through an
// external encoder and appends punctured parity. Optional RS_CTRL_BYPASS_EN.
module rs_ctrl #(
  parameter int W     = rs_pkg::W,
  parameter int NPAR  = rs_pkg::NPAR,
  parameter int K_MAX = rs_pkg::K_MAX
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   cfg_k,
  input  logic [3:0]   cfg_t,
`ifdef RS_CTRL_BYPASS_EN
  input  logic         cfg_bypass,
`endif
  output logic         cfg_err,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         enc_clr,
  output logic         enc_en,
  output logic         enc_sel,
  output logic [W-1:0] enc_din,
  input  logic [W-1:0] enc_dout
);

  import rs_pkg::state_e;
  import rs_pkg::IDLE;
  import rs_pkg::DATA;
  import rs_pkg::PARITY;
  import rs_pkg::T_MAX;

  localparam int         T_CAP_I = (NPAR / 2 < T_MAX) ? NPAR / 2 : T_MAX;
  localparam logic [3:0] T_CAP   = 4'(T_CAP_I);
  localparam logic [7:0] K_LIM   = 8'(K_MAX);

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d, cnt_nxt;
  logic [7:0]   k_q, k_d;
  logic [3:0]   t_q, t_d, t_in, t_eff;
  logic [7:0]   par_n;
  logic         armed_q;
  logic         byp_q;
  logic         cfg_ok;
  logic         can_load;
  logic         ld, ld_last;
  logic [W-1:0] ld_data;

`ifdef RS_CTRL_BYPASS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     byp_q <= 1'b0;
    else if (enc_clr) byp_q <= cfg_bypass;
  end
`else
  assign byp_q = 1'b0;
`endif

  assign cfg_ok  = (cfg_k != 8'd0) && (cfg_k <= K_LIM);
  assign t_in    = (cfg_t > T_CAP) ? T_CAP : cfg_t;
  assign t_eff   = byp_q ? 4'd0 : t_q;
  assign par_n   = {3'b000, t_eff, 1'b0};
  assign cnt_nxt = cnt_q + 8'd1;

  // NOTE: every signal written here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    t_d      = t_q;
    cfg_err  = 1'b0;
    enc_clr  = 1'b0;
    in_ready = 1'b0;
    enc_en   = 1'b0;
    enc_sel  = 1'b0;
    enc_din  = '0;
    ld       = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;

    case (state_q)
      IDLE: begin
        // armed_q keeps the decision quiet during and right after reset.
        if (armed_q && in_valid) begin
          if (cfg_ok) begin
            enc_clr = 1'b1;
            k_d     = cfg_k;
            t_d     = t_in;
            cnt_d   = 8'd0;
            state_d = DATA;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end
      DATA: begin
        in_ready = can_load;
        if (in_valid && can_load) begin
          ld      = 1'b1;
          ld_data = in_data;
          enc_en  = !byp_q;
          enc_din = in_data;
          if (cnt_nxt == k_q) begin
            cnt_d = 8'd0;
            if (par_n == 8'd0) begin
              ld_last = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = PARITY;
            end
          end else begin
            cnt_d = cnt_nxt;
          end
        end
      end
      PARITY: begin
        // Parity beyond 2*t stays in the encoder and is cleared next block.
        if (can_load) begin
          ld      = 1'b1;
          ld_data = enc_dout;
          enc_en  = 1'b1;
          enc_sel = 1'b1;
          if (cnt_nxt == par_n) begin
            ld_last = 1'b1;
            cnt_d   = 8'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      k_q     <= 8'd0;
      t_q     <= 4'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      t_q     <= t_d;
      armed_q <= 1'b1;
    end
  end

  rs_ctrl_oreg #(.W(W)) u_oreg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (ld),
    .data_i      (ld_data),
    .last_i      (ld_last),
    .out_ready_i (out_ready),
    .can_load_o  (can_load),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

endmodule
